// File: rtl/sat_adder_pkg.sv
// Shared types and constants for the saturating-adder inverse (decoder) path.
package sat_adder_pkg;

    localparam int WIDTH_DEFAULT = 5;
    localparam int SCALE_DEFAULT = 2;

    // Largest code the forward adder can emit; seeing it means the sum clipped.
    function automatic int sat_level(input int width);
        return (32'sd1 << width) - 32'sd1;
    endfunction

    localparam int SAT_VALUE_DEFAULT = sat_level(WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] b;
        logic [WIDTH_DEFAULT-1:0] rem;
        logic                     ambig;
        logic                     underflow;
    } result_t;

endpackage

// File: rtl/seq_restoring_div.sv
// Bit-serial restoring divider by a constant: one quotient bit per step, MSB first.
module seq_restoring_div #(
    parameter int WIDTH = 5,
    parameter int SCALE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] quot_next,
    output logic [WIDTH:0]   rem_next,
    output logic             done
);

    localparam logic [WIDTH:0] DIVISOR = (WIDTH+1)'(SCALE);

    logic [WIDTH:0]         rem_r;
    logic [WIDTH-1:0]       dvd_r;
    logic [$clog2(WIDTH+1)-1:0] cnt_r;
    logic [WIDTH:0]         shifted_s;
    logic                   qbit_s;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted_s = (rem_r << 1) | {{WIDTH{1'b0}}, dvd_r[WIDTH-1]};
        qbit_s    = (shifted_s >= DIVISOR);
        if (qbit_s) begin
            rem_next = shifted_s - DIVISOR;
        end else begin
            rem_next = shifted_s;
        end
        quot_next = {dvd_r[WIDTH-2:0], qbit_s};
        done      = step && (cnt_r == '0);
    end

    // Dividend register doubles as the quotient shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r <= '0;
            dvd_r <= '0;
            cnt_r <= '0;
        end else if (load) begin
            rem_r <= '0;
            dvd_r <= dividend;
            cnt_r <= ($bits(cnt_r))'(WIDTH - 1);
        end else if (step) begin
            rem_r <= rem_next;
            dvd_r <= quot_next;
            cnt_r <= cnt_r - 1'b1;
        end else begin
            rem_r <= rem_r;
            dvd_r <= dvd_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/sat_adder_inverse.sv
// Recovers b = (y - a) / SCALE from a saturating scaled-adder output, with
// remainder, saturation-ambiguity and underflow flags, behind valid/ready.
module sat_adder_inverse
    import sat_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SCALE = SCALE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] a_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] rem_out,
    output logic             ambig,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] SAT_VALUE = WIDTH'(sat_level(WIDTH));

    typedef struct packed {
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] rem;
        logic             ambig;
        logic             underflow;
    } res_t;

    state_t         state_r, state_next;
    res_t           res_r;
    logic           in_ready_r, out_valid_r, ambig_pend_r;
    logic           accept_s, load_s, step_s, done_s, borrow_s;
    logic [WIDTH:0] diff_s;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH:0] rem_s;

    seq_restoring_div #(.WIDTH(WIDTH), .SCALE(SCALE)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .step      (step_s),
        .dividend  (diff_s[WIDTH-1:0]),
        .quot_next (quot_s),
        .rem_next  (rem_s),
        .done      (done_s)
    );

    // Handshake FSM next-state and divider control.
    always_comb begin
        state_next = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        diff_s     = {1'b0, y_in} - {1'b0, a_in};
        borrow_s   = diff_s[WIDTH];
        accept_s   = in_valid && in_ready_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (borrow_s) begin
                        state_next = DONE;
                    end else begin
                        load_s     = 1'b1;
                        state_next = CALC;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (done_s) begin
                    state_next = DONE;
                end else begin
                    state_next = CALC;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, handshake flags and result registers; results publish only on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            ambig_pend_r <= 1'b0;
            res_r        <= '0;
        end else begin
            state_r     <= state_next;
            in_ready_r  <= (state_next == IDLE);
            out_valid_r <= (state_next == DONE);
            if (state_r == IDLE && accept_s) begin
                ambig_pend_r <= (y_in == SAT_VALUE);
            end else begin
                ambig_pend_r <= ambig_pend_r;
            end
            if (state_r == IDLE && accept_s && borrow_s) begin
                res_r <= '{b: '0, rem: '0, ambig: (y_in == SAT_VALUE), underflow: 1'b1};
            end else if (state_r == CALC && done_s) begin
                res_r <= '{b: quot_s, rem: WIDTH'(rem_s), ambig: ambig_pend_r, underflow: 1'b0};
            end else begin
                res_r <= res_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign b_out     = res_r.b;
    assign rem_out   = res_r.rem;
    assign ambig     = res_r.ambig;
    assign underflow = res_r.underflow;

endmodule

// File: tb/tb_sat_adder_inverse.sv
// Directed table-driven bench for sat_adder_inverse at WIDTH=5, SCALE=2.
module tb_sat_adder_inverse;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] y_in, a_in, b_out, rem_out;
    logic         ambig, underflow;

    int checks = 0;
    int errors = 0;

    sat_adder_inverse #(.WIDTH(W), .SCALE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .rem_out   (rem_out),
        .ambig     (ambig),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        int a;
        int hold;
        int exp_b;
        int exp_rem;
        int exp_amb;
        int exp_uf;
        int exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_timeout", int'(in_ready), 1);
    endtask

    // Called just after the accept edge; lat counts negedges from that edge.
    task automatic wait_result(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        out_ready = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        y_in = W'(v.y);
        a_in = W'(v.a);
        @(posedge clk);
        #1 in_valid = 1'b0;
        y_in = '0;
        a_in = '0;
        wait_result(lat);
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_b"}, int'(b_out), v.exp_b);
        check({tag, "_rem"}, int'(rem_out), v.exp_rem);
        check({tag, "_ambig"}, int'(ambig), v.exp_amb);
        check({tag, "_underflow"}, int'(underflow), v.exp_uf);
        check({tag, "_in_ready_done"}, int'(in_ready), 0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            check({tag, "_hold_b"}, int'(b_out), v.exp_b);
            check({tag, "_hold_rem"}, int'(rem_out), v.exp_rem);
            check({tag, "_hold_ambig"}, int'(ambig), v.exp_amb);
            check({tag, "_hold_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, int'(out_valid), 0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        vecs[0] = '{y: 11, a: 3,  hold: 0, exp_b: 4,  exp_rem: 0, exp_amb: 0, exp_uf: 0, exp_lat: 6};
        vecs[1] = '{y: 31, a: 20, hold: 0, exp_b: 5,  exp_rem: 1, exp_amb: 1, exp_uf: 0, exp_lat: 6};
        vecs[2] = '{y: 2,  a: 5,  hold: 0, exp_b: 0,  exp_rem: 0, exp_amb: 0, exp_uf: 1, exp_lat: 1};
        vecs[3] = '{y: 31, a: 0,  hold: 4, exp_b: 15, exp_rem: 1, exp_amb: 1, exp_uf: 0, exp_lat: 6};
        vecs[4] = '{y: 5,  a: 5,  hold: 0, exp_b: 0,  exp_rem: 0, exp_amb: 0, exp_uf: 0, exp_lat: 6};
        vecs[5] = '{y: 30, a: 0,  hold: 1, exp_b: 15, exp_rem: 0, exp_amb: 0, exp_uf: 0, exp_lat: 6};
        vecs[6] = '{y: 31, a: 31, hold: 0, exp_b: 0,  exp_rem: 0, exp_amb: 1, exp_uf: 0, exp_lat: 6};
        vecs[7] = '{y: 0,  a: 1,  hold: 2, exp_b: 0,  exp_rem: 0, exp_amb: 0, exp_uf: 1, exp_lat: 1};
        vecs[8] = '{y: 17, a: 0,  hold: 0, exp_b: 8,  exp_rem: 1, exp_amb: 0, exp_uf: 0, exp_lat: 6};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        y_in = '0;
        a_in = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_b", int'(b_out), 0);
        check("rst_rem", int'(rem_out), 0);
        check("rst_ambig", int'(ambig), 0);
        check("rst_underflow", int'(underflow), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during CALC discards the request.
        wait_ready();
        in_valid = 1'b1;
        y_in = W'(20);
        a_in = W'(4);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready_low", int'(in_ready), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        check("midrst_in_ready_high", int'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midrst_no_valid", int'(seen), 0);
        run_vec('{y: 9, a: 1, hold: 0, exp_b: 4, exp_rem: 0, exp_amb: 0, exp_uf: 0, exp_lat: 6}, "after_rst");

        // Back-to-back with out_ready tied high and in_valid held.
        wait_ready();
        out_ready = 1'b1;
        in_valid = 1'b1;
        y_in = W'(11);
        a_in = W'(3);
        @(posedge clk);
        #1 y_in = W'(30);
        a_in = W'(0);
        wait_result(lat);
        check("b2b_first_latency", lat, 6);
        check("b2b_first_b", int'(b_out), 4);
        check("b2b_first_rem", int'(rem_out), 0);
        @(negedge clk);
        check("b2b_gap_valid", int'(out_valid), 0);
        check("b2b_gap_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(lat);
        check("b2b_second_latency", lat, 6);
        check("b2b_second_b", int'(b_out), 15);
        check("b2b_second_rem", int'(rem_out), 0);
        check("b2b_second_ambig", int'(ambig), 0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("b2b_end_valid", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
